voice_mix: RTL and testbench
============================

VOICE_MIX -- requirements
Module: voice_mix

Interface
REQ-001 SHALL have parameter NVOICE, default 4: number of voice inputs (2..8).
REQ-002 SHALL have parameter PWM_DEPTH, default 12: output duty width.
REQ-003 SHALL have parameter DATAWIDTH, default 16: voice sample width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port tick, input, 1 bit: one-cycle sample-rate strobe that starts a mix.
REQ-007 SHALL have port voice_in, input, NVOICE*DATAWIDTH bits: offset-binary samples (0x8000 = silence), voice k at bits [k*16+15:k*16].
REQ-008 SHALL have port voice_en, input, NVOICE bits: per-voice include flag.
REQ-009 SHALL have port master_vol, input, 3 bits: arithmetic right-shift attenuation applied to the sum.
REQ-010 SHALL have port clip_clr, input, 1 bit: clears the sticky flags.
REQ-011 SHALL have port dc_out, output, PWM_DEPTH bits: registered duty word for the downstream PWM.
REQ-012 SHALL have port dc_valid, output, 1 bit: one-cycle pulse when dc_out updates.
REQ-013 SHALL have port busy, output, 1 bit: high while a mix is in progress.
REQ-014 SHALL have ports clip and overrun, outputs, 1 bit each: sticky saturation and missed-tick flags.

Function
REQ-015 SHALL implement FSM states IDLE, ACC, SCALE, OUT; busy = (state != IDLE).
REQ-016 SHALL, in IDLE with tick=1, snapshot voice_in, voice_en and master_vol, clear the accumulator, zero the voice index and enter ACC.
REQ-017 SHALL, in ACC, add one voice per cycle (index 0..NVOICE-1): sample XOR 0x8000 as signed, added only if its snapshot enable bit is set; enter SCALE after index NVOICE-1.
REQ-018 SHALL size the accumulator at DATAWIDTH+clog2(NVOICE) bits signed; no overflow inside ACC.
REQ-019 SHALL, in SCALE, arithmetic-shift the sum right by the snapshot master_vol, saturate to [-32768, 32767], and set clip if saturation occurred.
REQ-020 SHALL, in OUT, register dc_out = top PWM_DEPTH bits of (saturated value XOR 0x8000), pulse dc_valid for exactly one cycle and return to IDLE.
REQ-021 SHALL assert dc_valid exactly NVOICE+2 rising edges after the edge that sampled tick; a new tick is accepted on the cycle after dc_valid.
REQ-022 SHALL hold dc_out stable between dc_valid pulses.
REQ-023 SHALL ignore tick while busy and set overrun; the mix in progress completes unaffected.
REQ-024 SHALL leave the result unaffected by changes on voice_in, voice_en or master_vol after the snapshot.
REQ-025 SHALL clear clip and overrun on clip_clr; a same-cycle set event wins over clear.
REQ-026 SHALL treat all voices disabled as silence: dc_out = midscale 0x800.

Reset
REQ-027 SHALL, on rst_n low, immediately force state IDLE, accumulator 0, dc_out 0x800, and dc_valid, busy, clip and overrun all 0.
REQ-028 SHALL abandon a mix in progress when reset occurs mid-operation; dc_valid SHALL NOT pulse for that mix.

Structure
REQ-029 SHALL place DATAWIDTH, PWM_DEPTH, the silence constant 0x8000 and the FSM state encoding in the shared synth package.
REQ-030 SHALL be a single module with no sub-modules; the saturating shifter is inline logic.

Verification
REQ-031 SHALL cover silence: all voices 0x8000, all enabled, vol 0, tick -> dc_out 0x800, clip 0, dc_valid 6 edges after tick.
REQ-032 SHALL cover positive clip: all voices 0xFFFF, vol 0 -> dc_out 0xFFF, clip 1; repeated with clip_clr and vol 2 -> dc_out 0xFFF, clip 0.
REQ-033 SHALL cover negative clip: voices 0 and 1 at 0x0000, others disabled -> dc_out 0x000, clip 1; only voice 0 at 0x0000 -> dc_out 0x000, clip 0.
REQ-034 SHALL cover overrun: second tick 2 cycles after the first -> one dc_valid only, overrun 1, result equals the first snapshot.
REQ-035 SHALL cover snapshot isolation: voice_in changed during ACC -> dc_out reflects the pre-change values.
REQ-036 SHALL cover reset mid-ACC: rst_n low -> dc_out 0x800, busy 0, no dc_valid pulse; the next tick mixes normally.

Source files
------------

// File: rtl/voice_mix_pkg.sv
// Shared constants and FSM encoding for the voice mixer.
package voice_mix_pkg;

  localparam int DATAWIDTH = 16;
  localparam int PWM_DEPTH = 12;
  localparam logic [15:0] SILENCE = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_SCALE = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/voice_mix.sv
// Sequential voice mixer: on each tick, snapshots the voices, sums one per cycle,
// attenuates and saturates the sum, and emits an offset-binary PWM duty word.
module voice_mix #(
  parameter int NVOICE    = 4,
  parameter int PWM_DEPTH = voice_mix_pkg::PWM_DEPTH,
  parameter int DATAWIDTH = voice_mix_pkg::DATAWIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic [NVOICE*DATAWIDTH-1:0] voice_in,
  input  logic [NVOICE-1:0]           voice_en,
  input  logic [2:0]                  master_vol,
  input  logic                        clip_clr,
  output logic [PWM_DEPTH-1:0]        dc_out,
  output logic                        dc_valid,
  output logic                        busy,
  output logic                        clip,
  output logic                        overrun,
  output logic [1:0]                  state_dbg
);
  import voice_mix_pkg::*;

  localparam int IDXW = (NVOICE > 1) ? $clog2(NVOICE) : 1;
  localparam int ACCW = DATAWIDTH + $clog2(NVOICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NVOICE - 1);
  localparam logic [DATAWIDTH-1:0] SIL = {1'b1, {(DATAWIDTH-1){1'b0}}};
  localparam logic [PWM_DEPTH-1:0] DC_MID = {1'b1, {(PWM_DEPTH-1){1'b0}}};
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((2 ** (DATAWIDTH - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  state_t                        state_q, state_d;
  logic [NVOICE*DATAWIDTH-1:0]   voice_snap_q, voice_snap_d;
  logic [NVOICE-1:0]             en_snap_q, en_snap_d;
  logic [2:0]                    vol_snap_q, vol_snap_d;
  logic signed [ACCW-1:0]        acc_q, acc_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [DATAWIDTH-1:0]          sat_q, sat_d;
  logic [PWM_DEPTH-1:0]          dc_out_q, dc_out_d;
  logic                          dc_valid_q, dc_valid_d;
  logic                          clip_q, clip_d;
  logic                          overrun_q, overrun_d;

  logic signed [DATAWIDTH-1:0]   sample_s;
  logic signed [ACCW-1:0]        sample_ext;
  logic signed [ACCW-1:0]        shifted;
  logic [DATAWIDTH-1:0]          out_word;
  logic                          clip_set;
  logic                          overrun_set;

  always_comb begin
    state_d      = state_q;
    voice_snap_d = voice_snap_q;
    en_snap_d    = en_snap_q;
    vol_snap_d   = vol_snap_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    sat_d        = sat_q;
    dc_out_d     = dc_out_q;
    dc_valid_d   = 1'b0;
    clip_set     = 1'b0;
    overrun_set  = 1'b0;
    sample_s     = $signed(voice_snap_q[int'(idx_q)*DATAWIDTH +: DATAWIDTH] ^ SIL);
    sample_ext   = ACCW'(sample_s);
    shifted      = acc_q >>> vol_snap_q;
    out_word     = sat_q ^ SIL;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          voice_snap_d = voice_in;
          en_snap_d    = voice_en;
          vol_snap_d   = master_vol;
          acc_d        = '0;
          idx_d        = '0;
          state_d      = ST_ACC;
        end
      end
      ST_ACC: begin
        if (en_snap_q[idx_q]) acc_d = acc_q + sample_ext;
        if (idx_q == LAST_IDX) state_d = ST_SCALE;
        else idx_d = idx_q + 1'b1;
      end
      ST_SCALE: begin
        if (shifted > SAT_MAX) begin
          sat_d    = SAT_MAX[DATAWIDTH-1:0];
          clip_set = 1'b1;
        end else if (shifted < SAT_MIN) begin
          sat_d    = SAT_MIN[DATAWIDTH-1:0];
          clip_set = 1'b1;
        end else begin
          sat_d = shifted[DATAWIDTH-1:0];
        end
        state_d = ST_OUT;
      end
      ST_OUT: begin
        dc_out_d   = out_word[DATAWIDTH-1 -: PWM_DEPTH];
        dc_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick that lands mid-mix is dropped; only the flag records it.
    if (tick && (state_q != ST_IDLE)) overrun_set = 1'b1;

    clip_d    = clip_set    ? 1'b1 : (clip_clr ? 1'b0 : clip_q);
    overrun_d = overrun_set ? 1'b1 : (clip_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      voice_snap_q <= '0;
      en_snap_q    <= '0;
      vol_snap_q   <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      sat_q        <= '0;
      dc_out_q     <= DC_MID;
      dc_valid_q   <= 1'b0;
      clip_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      voice_snap_q <= voice_snap_d;
      en_snap_q    <= en_snap_d;
      vol_snap_q   <= vol_snap_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      sat_q        <= sat_d;
      dc_out_q     <= dc_out_d;
      dc_valid_q   <= dc_valid_d;
      clip_q       <= clip_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dc_out    = dc_out_q;
  assign dc_valid  = dc_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign clip      = clip_q;
  assign overrun   = overrun_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_voice_mix.sv
// Directed bench for voice_mix: silence, clipping, overrun, snapshot isolation and reset.
module tb_voice_mix;

  localparam int NV = 4;
  localparam int DW = 16;
  localparam int PD = 12;

  logic           clk;
  logic           rst_n;
  logic           tick;
  logic [NV*DW-1:0] voice_in;
  logic [NV-1:0]  voice_en;
  logic [2:0]     master_vol;
  logic           clip_clr;
  logic [PD-1:0]  dc_out;
  logic           dc_valid;
  logic           busy;
  logic           clip;
  logic           overrun;
  logic [1:0]     state_dbg;

  int tests_run;
  int tests_failed;

  voice_mix #(.NVOICE(NV), .PWM_DEPTH(PD), .DATAWIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .voice_in   (voice_in),
    .voice_en   (voice_en),
    .master_vol (master_vol),
    .clip_clr   (clip_clr),
    .dc_out     (dc_out),
    .dc_valid   (dc_valid),
    .busy       (busy),
    .clip       (clip),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic set_all_voices(input logic [DW-1:0] v);
    for (int k = 0; k < NV; k++) voice_in[k*DW +: DW] = v;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic pulse_clr();
    clip_clr = 1'b1;
    @(posedge clk);
    #1;
    clip_clr = 1'b0;
  endtask

  // Watches a bounded window; lat = 0 means no pulse was seen.
  task automatic wait_valid(output int lat, output int pulses, output logic [PD-1:0] dc_seen);
    lat = 0;
    pulses = 0;
    dc_seen = '0;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      #1;
      if (dc_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = n;
          dc_seen = dc_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (dc_out !== 12'h800) begin tests_failed++; $display("FAIL reset_dc_out got %h want 800", dc_out); end
    tests_run++;
    if (dc_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dc_valid got %b want 0", dc_valid); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (clip !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags got clip=%b ovr=%b want 0 0", clip, overrun);
    end
    tests_run++;
    if (state_dbg !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_silence();
    int lat, pulses;
    logic [PD-1:0] seen;
    set_all_voices(16'h8000);
    voice_en = 4'hF;
    master_vol = 3'd0;
    pulse_tick();
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL silence_busy got %b want 1", busy); end
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (lat !== 6) begin tests_failed++; $display("FAIL silence_latency got %0d want 6", lat); end
    tests_run++;
    if (seen !== 12'h800) begin tests_failed++; $display("FAIL silence_dc got %h want 800", seen); end
    tests_run++;
    if (clip !== 1'b0) begin tests_failed++; $display("FAIL silence_clip got %b want 0", clip); end
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL silence_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_pos_clip();
    int lat, pulses;
    logic [PD-1:0] seen;
    set_all_voices(16'hFFFF);
    voice_en = 4'hF;
    master_vol = 3'd0;
    pulse_tick();
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (seen !== 12'hFFF) begin tests_failed++; $display("FAIL pos_clip_dc got %h want fff", seen); end
    tests_run++;
    if (clip !== 1'b1) begin tests_failed++; $display("FAIL pos_clip_flag got %b want 1", clip); end
    pulse_clr();
    tests_run++;
    if (clip !== 1'b0) begin tests_failed++; $display("FAIL pos_clip_clr got %b want 0", clip); end
    master_vol = 3'd2;
    pulse_tick();
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (seen !== 12'hFFF) begin tests_failed++; $display("FAIL pos_vol2_dc got %h want fff", seen); end
    tests_run++;
    if (clip !== 1'b0) begin tests_failed++; $display("FAIL pos_vol2_clip got %b want 0", clip); end
  endtask

  task automatic test_neg_clip();
    int lat, pulses;
    logic [PD-1:0] seen;
    set_all_voices(16'h0000);
    voice_en = 4'b0011;
    master_vol = 3'd0;
    pulse_tick();
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (seen !== 12'h000) begin tests_failed++; $display("FAIL neg_clip_dc got %h want 000", seen); end
    tests_run++;
    if (clip !== 1'b1) begin tests_failed++; $display("FAIL neg_clip_flag got %b want 1", clip); end
    pulse_clr();
    voice_en = 4'b0001;
    pulse_tick();
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (seen !== 12'h000) begin tests_failed++; $display("FAIL neg_single_dc got %h want 000", seen); end
    tests_run++;
    if (clip !== 1'b0) begin tests_failed++; $display("FAIL neg_single_clip got %b want 0", clip); end
  endtask

  task automatic test_all_disabled();
    int lat, pulses;
    logic [PD-1:0] seen;
    set_all_voices(16'hFFFF);
    voice_en = 4'b0000;
    master_vol = 3'd0;
    pulse_tick();
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (seen !== 12'h800) begin tests_failed++; $display("FAIL disabled_dc got %h want 800", seen); end
    tests_run++;
    if (dc_out !== 12'h800) begin tests_failed++; $display("FAIL disabled_hold got %h want 800", dc_out); end
  endtask

  task automatic test_overrun();
    int lat, pulses;
    logic [PD-1:0] seen;
    pulse_clr();
    set_all_voices(16'h8000);
    voice_in[0 +: DW] = 16'hC000;
    voice_en = 4'hF;
    master_vol = 3'd0;
    pulse_tick();
    @(posedge clk);
    #1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    set_all_voices(16'h0000);
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (lat !== 4) begin tests_failed++; $display("FAIL overrun_latency got %0d want 4", lat); end
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL overrun_pulses got %0d want 1", pulses); end
    tests_run++;
    if (seen !== 12'hC00) begin tests_failed++; $display("FAIL overrun_dc got %h want c00", seen); end
    tests_run++;
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_flag got %b want 1", overrun); end
    pulse_clr();
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_clr got %b want 0", overrun); end
  endtask

  task automatic test_snapshot();
    int lat, pulses;
    logic [PD-1:0] seen;
    set_all_voices(16'h8000);
    voice_in[0 +: DW] = 16'h9000;
    voice_in[DW +: DW] = 16'h9000;
    voice_en = 4'b0011;
    master_vol = 3'd1;
    pulse_tick();
    set_all_voices(16'hFFFF);
    voice_en = 4'hF;
    master_vol = 3'd0;
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (seen !== 12'h900) begin tests_failed++; $display("FAIL snapshot_dc got %h want 900", seen); end
    tests_run++;
    if (clip !== 1'b0) begin tests_failed++; $display("FAIL snapshot_clip got %b want 0", clip); end
  endtask

  task automatic test_reset_mid_acc();
    int lat, pulses;
    logic [PD-1:0] seen;
    set_all_voices(16'hFFFF);
    voice_en = 4'hF;
    master_vol = 3'd0;
    pulse_tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (dc_out !== 12'h800) begin tests_failed++; $display("FAIL midrst_dc got %h want 800", dc_out); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b want 0", busy); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL midrst_pulses got %0d want 0", pulses); end
    set_all_voices(16'h8000);
    voice_in[2*DW +: DW] = 16'hA000;
    voice_in[3*DW +: DW] = 16'hA000;
    voice_en = 4'b1100;
    pulse_tick();
    wait_valid(lat, pulses, seen);
    tests_run++;
    if (lat !== 6) begin tests_failed++; $display("FAIL postrst_latency got %0d want 6", lat); end
    tests_run++;
    if (seen !== 12'hC00) begin tests_failed++; $display("FAIL postrst_dc got %h want c00", seen); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    tick = 1'b0;
    clip_clr = 1'b0;
    voice_in = '0;
    voice_en = '0;
    master_vol = 3'd0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_silence();
    test_pos_clip();
    test_neg_clip();
    test_all_disabled();
    test_overrun();
    test_snapshot();
    test_reset_mid_acc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
